jtopl_timer_ctrl: RTL and testbench

CPU-side control stage that drives the OPL2 timer pair.
- Decodes the two-port bus (address latch, then data) into timer registers 0x02, 0x03 and 0x04.
- Produces the start values, load, flag-enable and flag-clear strobes consumed by the timers.
- Generates the once-per-sample `zero` tick from `cenop`.
- Returns the status byte built from the timer flags.

---
 rtl/jtopl_timer_pkg.sv | 27 ++
 rtl/jtopl_timer_ctrl_if.sv | 11 +
 rtl/jtopl_slot_cnt.sv | 40 ++++
 rtl/jtopl_timer_ctrl.sv | 121 ++++++++++++
 tb/tb_jtopl_timer_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/jtopl_timer_pkg.sv
// Shared constants for the OPL2 timer control stage: register map,
// control-register bit positions and bus port selection.
package jtopl_timer_pkg;

    localparam logic [7:0] REG_TA   = 8'h02;
    localparam logic [7:0] REG_TB   = 8'h03;
    localparam logic [7:0] REG_CTRL = 8'h04;

    localparam int unsigned IRQ_RST = 7;
    localparam int unsigned MASK_A  = 6;
    localparam int unsigned MASK_B  = 5;
    localparam int unsigned ST_B    = 1;
    localparam int unsigned ST_A    = 0;

    localparam int unsigned SLOTS_DEF = 18;

    typedef enum logic {
        PORT_ADDR = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    // Flag-clear is requested when a mask bit goes from 0 to 1.
    function automatic logic mask_rise(input logic old_m, input logic new_m);
        return new_m & ~old_m;
    endfunction

endpackage

// File: rtl/jtopl_timer_ctrl_if.sv
// CPU bus seen by the timer control stage: two-port write path plus status read.
interface jtopl_timer_ctrl_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs_n, output wr_n, output addr, output din, input dout);
    modport slave  (input cs_n, input wr_n, input addr, input din, output dout);
endinterface

// File: rtl/jtopl_slot_cnt.sv
// Operator slot counter; zero is high while the last slot of a sample is active.
module jtopl_slot_cnt
    import jtopl_timer_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cenop,
    output logic [$clog2(SLOTS)-1:0] slot,
    output logic                     zero
);
    localparam int unsigned W = $clog2(SLOTS);
    localparam logic [W-1:0] LAST = W'(SLOTS - 1);

    logic [W-1:0] slot_q, slot_d;
    logic         zero_q, zero_d;

    always_comb begin
        slot_d = slot_q;
        zero_d = zero_q;
        if (cenop) begin
            slot_d = (slot_q == LAST) ? '0 : slot_q + W'(1);
            zero_d = (slot_d == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            zero_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            zero_q <= zero_d;
        end
    end

    assign slot = slot_q;
    assign zero = zero_q;
endmodule

// File: rtl/jtopl_timer_ctrl.sv
// CPU-side control for the OPL2 timer pair: bus decode of regs 0x02-0x04,
// timer start/mask strobes, per-sample zero tick and status byte.
module jtopl_timer_ctrl
    import jtopl_timer_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cenop,
    jtopl_timer_ctrl_if.slave        bus,
    input  logic                     flag_A,
    input  logic                     flag_B,
    input  logic                     irq_n,
    output logic                     zero,
    output logic [7:0]               value_A,
    output logic [7:0]               value_B,
    output logic                     load_A,
    output logic                     load_B,
    output logic                     flagen_A,
    output logic                     flagen_B,
    output logic                     clr_flag_A,
    output logic                     clr_flag_B
);
    logic [$clog2(SLOTS)-1:0] slot;

    jtopl_slot_cnt #(.SLOTS(SLOTS)) u_slot_cnt (
        .clk   (clk),
        .rst   (rst),
        .cenop (cenop),
        .slot  (slot),
        .zero  (zero)
    );

    assert property (@(posedge clk) disable iff (rst)
        zero == (slot == ($clog2(SLOTS))'(SLOTS - 1)));

    logic       wr, wr_edge;
    logic       wr_l_q;
    logic [7:0] sel_q, sel_d;
    logic [7:0] value_A_q, value_A_d, value_B_q, value_B_d;
    logic       load_A_q, load_A_d, load_B_q, load_B_d;
    logic       mask_A_q, mask_A_d, mask_B_q, mask_B_d;
    logic       clr_A_q, clr_A_d, clr_B_q, clr_B_d;

    assign wr      = ~bus.cs_n & ~bus.wr_n;
    assign wr_edge = wr & ~wr_l_q;

    always_comb begin
        sel_d     = sel_q;
        value_A_d = value_A_q;
        value_B_d = value_B_q;
        load_A_d  = load_A_q;
        load_B_d  = load_B_q;
        mask_A_d  = mask_A_q;
        mask_B_d  = mask_B_q;
        clr_A_d   = 1'b0;
        clr_B_d   = 1'b0;
        if (wr_edge) begin
            if (port_e'(bus.addr) == PORT_ADDR) begin
                sel_d = bus.din;
            end else begin
                case (sel_q)
                    REG_TA: value_A_d = bus.din;
                    REG_TB: value_B_d = bus.din;
                    REG_CTRL: begin
                        // IRQ reset leaves masks and starts untouched
                        if (bus.din[IRQ_RST]) begin
                            clr_A_d = 1'b1;
                            clr_B_d = 1'b1;
                        end else begin
                            mask_A_d = bus.din[MASK_A];
                            mask_B_d = bus.din[MASK_B];
                            load_A_d = bus.din[ST_A];
                            load_B_d = bus.din[ST_B];
                            clr_A_d  = mask_rise(mask_A_q, bus.din[MASK_A]);
                            clr_B_d  = mask_rise(mask_B_q, bus.din[MASK_B]);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_l_q    <= 1'b1;
            sel_q     <= '0;
            value_A_q <= '0;
            value_B_q <= '0;
            load_A_q  <= 1'b0;
            load_B_q  <= 1'b0;
            mask_A_q  <= 1'b0;
            mask_B_q  <= 1'b0;
            clr_A_q   <= 1'b0;
            clr_B_q   <= 1'b0;
        end else begin
            wr_l_q    <= wr;
            sel_q     <= sel_d;
            value_A_q <= value_A_d;
            value_B_q <= value_B_d;
            load_A_q  <= load_A_d;
            load_B_q  <= load_B_d;
            mask_A_q  <= mask_A_d;
            mask_B_q  <= mask_B_d;
            clr_A_q   <= clr_A_d;
            clr_B_q   <= clr_B_d;
        end
    end

    assign value_A    = value_A_q;
    assign value_B    = value_B_q;
    assign load_A     = load_A_q;
    assign load_B     = load_B_q;
    assign flagen_A   = ~mask_A_q;
    assign flagen_B   = ~mask_B_q;
    assign clr_flag_A = clr_A_q;
    assign clr_flag_B = clr_B_q;
    assign bus.dout   = {~irq_n, flag_A, flag_B, 5'b00000};
endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Directed bench for jtopl_timer_ctrl with hand-computed expectations.
module tb_jtopl_timer_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cenop = 1'b0;
    logic       flag_A = 1'b0;
    logic       flag_B = 1'b0;
    logic       irq_n = 1'b1;
    logic       zero;
    logic [7:0] value_A, value_B;
    logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    jtopl_timer_ctrl_if bus();

    jtopl_timer_ctrl #(.SLOTS(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .cenop      (cenop),
        .bus        (bus),
        .flag_A     (flag_A),
        .flag_B     (flag_B),
        .irq_n      (irq_n),
        .zero       (zero),
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic la, input logic lb,
                              input logic fa, input logic fb, input logic ca, input logic cb);
        check({tag, ".load_A"},   {7'd0, load_A},     {7'd0, la});
        check({tag, ".load_B"},   {7'd0, load_B},     {7'd0, lb});
        check({tag, ".flagen_A"}, {7'd0, flagen_A},   {7'd0, fa});
        check({tag, ".flagen_B"}, {7'd0, flagen_B},   {7'd0, fb});
        check({tag, ".clr_A"},    {7'd0, clr_flag_A}, {7'd0, ca});
        check({tag, ".clr_B"},    {7'd0, clr_flag_B}, {7'd0, cb});
    endtask

    // Assert the strobe; returns at the negedge after the sampling edge.
    task automatic bus_start(input logic a, input logic [7:0] d);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = a;
        bus.din  = d;
        @(negedge clk);
    endtask

    task automatic bus_end();
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        bus_start(a, d);
        bus_end();
    endtask

    task automatic run_ticks(input string tag, input int unsigned n, input int unsigned period);
        for (int unsigned k = 1; k <= n; k++) begin
            @(negedge clk);
            check($sformatf("%s.zero@%0d", tag, k), {7'd0, zero}, {7'd0, (k % period) == 0});
            cenop = 1'b1;
            @(negedge clk);
            cenop = 1'b0;
        end
    endtask

    initial begin
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.addr = 1'b0;
        bus.din  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.value_A", value_A, 8'h00);
        check("rst.value_B", value_B, 8'h00);
        check("rst.zero", {7'd0, zero}, 8'h00);
        check("rst.dout", bus.dout, 8'h00);
        check_ctrl("rst", 0, 0, 1, 1, 0, 0);
        rst = 1'b0;

        run_ticks("cnt", 40, 18);
        check("post_cnt.dout", bus.dout, 8'h00);
        check_ctrl("post_cnt", 0, 0, 1, 1, 0, 0);

        // value_A written once; changing din during the held strobe must not rewrite it
        bus_write(1'b0, 8'h02);
        bus_start(1'b1, 8'hF0);
        check("ta.first", value_A, 8'hF0);
        bus.din = 8'h0F;
        repeat (4) @(negedge clk);
        bus_end();
        check("ta.held", value_A, 8'hF0);

        bus_write(1'b0, 8'h04);
        bus_start(1'b1, 8'h01);
        check_ctrl("st_a", 1, 0, 1, 1, 0, 0);
        bus.din = 8'h02;
        repeat (4) @(negedge clk);
        bus_end();
        check_ctrl("st_a.held", 1, 0, 1, 1, 0, 0);

        // Mask both: 0->1 on each mask fires both clears for one clk
        bus_start(1'b1, 8'h60);
        check_ctrl("mask", 0, 0, 0, 0, 1, 1);
        bus_end();
        check_ctrl("mask.after", 0, 0, 0, 0, 0, 0);

        flag_A = 1'b1;
        irq_n  = 1'b0;
        #1 check("dout.C0", bus.dout, 8'hC0);

        bus_start(1'b1, 8'h80);
        check_ctrl("irqrst", 0, 0, 0, 0, 1, 1);
        bus_end();
        check_ctrl("irqrst.after", 0, 0, 0, 0, 0, 0);

        // Masks already set: no clear pulse, only start B changes
        bus_start(1'b1, 8'h62);
        check_ctrl("remask", 0, 1, 0, 0, 0, 0);
        bus_end();

        flag_B = 1'b1;
        #1 check("dout.E0", bus.dout, 8'hE0);
        irq_n = 1'b1;
        #1 check("dout.60", bus.dout, 8'h60);

        bus_write(1'b0, 8'h05);
        bus_write(1'b1, 8'hAA);
        check("sel5.value_A", value_A, 8'hF0);
        check("sel5.value_B", value_B, 8'h00);
        check_ctrl("sel5", 0, 1, 0, 0, 0, 0);

        bus_write(1'b0, 8'h03);
        bus_write(1'b1, 8'h33);
        check("tb.first", value_B, 8'h33);
        bus_write(1'b1, 8'h44);
        check("tb.repeat", value_B, 8'h44);

        // cenop and write on the same edge
        @(negedge clk);
        cenop    = 1'b1;
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = 1'b1;
        bus.din  = 8'h55;
        @(negedge clk);
        cenop = 1'b0;
        check("cen_wr.value_B", value_B, 8'h55);
        bus_end();

        // Reset during a held address strobe that would select reg 0x02
        bus_start(1'b0, 8'h02);
        rst = 1'b1;
        #1;
        check("arst.value_A", value_A, 8'h00);
        check("arst.value_B", value_B, 8'h00);
        check("arst.zero", {7'd0, zero}, 8'h00);
        check_ctrl("arst", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus_end();
        bus_write(1'b1, 8'h77);
        check("arst.nowrite", value_A, 8'h00);
        bus_write(1'b0, 8'h02);
        bus_write(1'b1, 8'h77);
        check("arst.rewrite", value_A, 8'h77);

        run_ticks("cnt2", 18, 18);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
